// File: rtl/port_in_conditioner.sv
// port_in_conditioner: synchronizes and debounces slide switches and push buttons for PortIn,
// and captures button presses as sticky flags that software acknowledges.
module port_in_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk_base,
    input  logic       rst_n,
    input  logic [3:0] slide,
    input  logic [1:0] button,
    input  logic [1:0] clear,
    output logic [3:0] port0,
    output logic [3:0] port1,
    output logic [1:0] press_evt
);
    localparam int              N    = 6;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     raw, s1_q, s2_q, lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [1:0]       evt_q, evt_d, flag_q, flag_d;

    // Buttons are inverted up front so every channel is active-high and resets to "released".
    assign raw = {~button, slide};

    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == LAST) lvl_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        evt_d  = lvl_d[5:4] & ~lvl_q[5:4];
        flag_d = evt_d | (flag_q & ~clear);
    end

    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            lvl_q  <= '0;
            evt_q  <= '0;
            flag_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            evt_q  <= evt_d;
            flag_q <= flag_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign port0     = lvl_q[3:0];
    assign port1     = {flag_q, lvl_q[5:4]};
    assign press_evt = evt_q;
endmodule

// File: tb/tb_port_in_conditioner.sv
// tb_port_in_conditioner: directed checks of debounce latency, glitch rejection,
// sticky press flags, set/clear collision and reset behaviour with DEBOUNCE_CYCLES=4.
module tb_port_in_conditioner;
    logic       clk_base = 1'b0;
    logic       rst_n;
    logic [3:0] slide;
    logic [1:0] button;
    logic [1:0] clear;
    logic [3:0] port0;
    logic [3:0] port1;
    logic [1:0] press_evt;
    logic [1:0] evt_or;
    logic [3:0] p1_or;
    int         tests = 0;
    int         fails = 0;

    port_in_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk_base (clk_base),
        .rst_n    (rst_n),
        .slide    (slide),
        .button   (button),
        .clear    (clear),
        .port0    (port0),
        .port1    (port1),
        .press_evt(press_evt)
    );

    always #5 clk_base = ~clk_base;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_base);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        slide  = 4'hF;
        button = 2'b00;
        clear  = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_port0", 8'(port0), 8'h0);
        chk("rst_async_port1", 8'(port1), 8'h0);
        chk("rst_async_evt", 8'(press_evt), 8'h0);
        tick(3);
        chk("rst_held_port0", 8'(port0), 8'h0);
        rst_n = 1'b1;
        tick(5);
        chk("rst_e5_port0", 8'(port0), 8'h0);
        chk("rst_e5_port1", 8'(port1), 8'h0);
        tick();
        chk("rst_e6_port0", 8'(port0), 8'hF);
        chk("rst_e6_port1", 8'(port1), 8'hF);
        chk("rst_e6_evt", 8'(press_evt), 8'h3);
        tick();
        chk("rst_e7_evt", 8'(press_evt), 8'h0);
        chk("rst_e7_port1", 8'(port1), 8'hF);

        button = 2'b11;
        tick(8);
        chk("release_flags_kept", 8'(port1), 8'hC);
        clear = 2'b11;
        tick();
        clear = 2'b00;
        chk("clear_both", 8'(port1), 8'h0);
        clear = 2'b11;
        tick();
        clear = 2'b00;
        chk("clear_idle", 8'(port1), 8'h0);

        slide = 4'h0;
        tick(8);
        chk("slide_zero", 8'(port0), 8'h0);
        slide = 4'h5;
        tick(5);
        chk("lat_e5", 8'(port0), 8'h0);
        tick();
        chk("lat_e6", 8'(port0), 8'h5);

        evt_or = '0;
        p1_or  = '0;
        button = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            evt_or |= press_evt;
            p1_or  |= port1;
        end
        button = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            evt_or |= press_evt;
            p1_or  |= port1;
        end
        chk("glitch3_port1", 8'(p1_or), 8'h0);
        chk("glitch3_evt", 8'(evt_or), 8'h0);

        button = 2'b10;
        tick(4);
        button = 2'b11;
        tick();
        chk("pulse4_e5_port1", 8'(port1), 8'h0);
        tick();
        chk("pulse4_e6_port1", 8'(port1), 8'h5);
        chk("pulse4_e6_evt", 8'(press_evt), 8'h1);
        tick();
        chk("pulse4_e7_evt", 8'(press_evt), 8'h0);
        tick(6);
        chk("pulse4_released", 8'(port1), 8'h4);
        clear = 2'b01;
        tick();
        clear = 2'b00;
        chk("pulse4_clear", 8'(port1), 8'h0);

        button = 2'b01;
        tick(6);
        chk("b1_press_port1", 8'(port1), 8'hA);
        chk("b1_press_evt", 8'(press_evt), 8'h2);
        button = 2'b11;
        evt_or = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            evt_or |= press_evt;
        end
        chk("b1_release_sticky", 8'(port1), 8'h8);
        chk("b1_release_no_evt", 8'(evt_or), 8'h0);
        clear = 2'b10;
        tick();
        clear = 2'b00;
        chk("b1_clear", 8'(port1), 8'h0);

        button = 2'b01;
        tick(5);
        clear = 2'b10;
        tick();
        clear = 2'b00;
        chk("collide_port1", 8'(port1), 8'hA);
        chk("collide_evt", 8'(press_evt), 8'h2);
        button = 2'b11;
        tick(8);
        chk("collide_release", 8'(port1), 8'h8);
        clear = 2'b10;
        tick();
        clear = 2'b00;
        chk("collide_clear", 8'(port1), 8'h0);

        slide = 4'h0;
        tick(8);
        chk("mid_pre", 8'(port0), 8'h0);
        slide = 4'h4;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_port0", 8'(port0), 8'h0);
        tick();
        rst_n = 1'b1;
        tick(5);
        chk("mid_e5_port0", 8'(port0), 8'h0);
        tick();
        chk("mid_e6_port0", 8'(port0), 8'h4);
        chk("mid_e6_port1", 8'(port1), 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/port_in_conditioner.md
# port_in_conditioner

Input-side stage that turns the raw board slide switches and push buttons into clean, clock-synchronous port data for the SIPS4 datapath's `PortIn` bus. Every raw input bit gets a two-flop synchronizer and a per-bit debounce counter. Button presses are also captured as sticky flags that software clears through a per-button acknowledge. The outputs `port1`/`port0` connect directly to `PortIn[7:4]`/`PortIn[3:0]`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 1 to 2^CNT_W-1.
- `CNT_W`, 20: debounce counter width.

Ports:
- `clk_base`, in, 1: the single system clock (50 MHz).
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `slide`, in, 4: raw slide switches, active-high, asynchronous.
- `button`, in, 2: raw push buttons, active-low (0 = pressed), asynchronous.
- `clear`, in, 2: synchronous; `clear[i]`=1 for one cycle clears press flag i.
- `port0`, out, 4: debounced slide levels.
- `port1`, out, 4: `{press_flag[1:0], btn_level[1:0]}`. `btn_level[i]`=1 while button i is held (debounced, polarity inverted).
- `press_evt`, out, 2: one-cycle pulse on each accepted press (debounced 0→1 of `btn_level`).

## Operation
- There are 6 independent channels. Channels 0..3 are `slide[3:0]`. Channels 4..5 are `~button[1:0]`, inverted before the synchronizer so every channel is active-high.
- Per channel: `s1`→`s2` synchronizer, then a `CNT_W`-bit counter `cnt` and a stable level `lvl`.
- Each cycle:
  - If `s2 == lvl`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` resets the count and never reaches `lvl`.
- `port0 = lvl[3:0]`. `btn_level = lvl[5:4]`.
- `press_evt[i]` is a registered pulse, high in the cycle after the clock edge where `lvl[4+i]` goes 0→1. Release (1→0) produces no event.
- `press_flag[i]`:
  - Set when `press_evt[i]` is generated, in the same edge `press_evt[i]` registers.
  - Cleared at an edge where `clear[i]`=1.
  - If set and clear occur at the same edge, set wins and the flag stays 1.
  - `clear` on an already-clear flag has no effect.
- All outputs are registered; there is no combinational path from any input to any output.

## Timing
- Reset (asynchronous assert, held while `rst_n`=0):
  - `s1`, `s2`, `lvl`, `cnt`, `press_flag`, `press_evt` all 0, so `port0`=0, `port1`=0, `press_evt`=0.
  - Button channels reset to 0 = released, so a button held through reset is reported as a press `DEBOUNCE_CYCLES`+2 edges after reset deasserts.
- Level latency: raw input changes before edge 0 and stays constant.
  - `s2` takes the new value at edge 2.
  - `lvl` and `port*` change at edge 2+`DEBOUNCE_CYCLES`.
  - `press_evt` and `press_flag` rise at that same edge.
- With `DEBOUNCE_CYCLES`=1, `lvl` follows `s2` one edge later (edge 3).
- Counter never wraps: it is bounded by `DEBOUNCE_CYCLES-1`, and `CNT_W` must hold that value.
- Reset asserted mid-count: all counters and flags are lost immediately, and no `press_evt` is emitted for the interrupted transition.
- `press_evt` is exactly one cycle wide. Consecutive accepted presses are at least 2·`DEBOUNCE_CYCLES` cycles apart, because a release must also be accepted in between.
- Channels are independent; simultaneous transitions on several channels resolve in the same cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: `rst_n`=0 with `slide`=4'hF, `button`=2'b00 → `port0`=0, `port1`=0, `press_evt`=0 asynchronously. After release, `port0`=4'hF and `port1`=4'b1111 at edge 6; `press_evt`=2'b11 during the cycle after edge 6 only.
- Debounce latency: `slide`=4'h0→4'h5 before edge 0 → `port0` still 0 after edge 5, `port0`=4'h5 after edge 6.
- Glitch rejection: `button[0]` low for 3 cycles, then high → `port1`=0 throughout, `press_evt`=0. A 4-cycle low pulse (after sync) → `port1`=4'b0101, one `press_evt`=2'b01.
- Sticky flag and clear: press and release `button[1]` → `port1[3]`=1 persists after release (`port1`=4'b1000). Pulse `clear`=2'b10 → `port1`=0 next cycle.
- Set/clear collision: assert `clear[1]` in the same cycle the `button[1]` press is accepted → `press_flag[1]` remains 1.
- Reset mid-count: `slide[2]` goes high, `rst_n` pulsed low at edge 4, input held high → `port0[2]` rises at edge 6 after reset release and no earlier.
